imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Streams a program image into the CPU instruction memory over a byte valid/ready
//  link, replacing the simulation-only $readmemb backdoor. Writes imem word by word,
//  holds the CPU disabled while loading, then raises cpu_en once the image is complete.
//  Sits between the host/UART byte source and the imem write port of the control unit.
// PARAMETERS
//  IW     16   instruction word width in bits; bytes per word BPW = (IW+7)/8
//  DEPTH  256  imem depth in words; AW = $clog2(DEPTH)
// PORTS
//  clk      in   1   system clock
//  rst      in   1   asynchronous, active-low reset
//  start    in   1   one-cycle pulse: begin a new load; ignored unless in IDLE, DONE or ERR
//  s_data   in   8   input byte
//  s_valid  in   1   s_data valid
//  s_ready  out  1   loader accepts byte; transfer when s_valid && s_ready
//  im_we    out  1   imem write strobe, one cycle per word
//  im_addr  out  AW  imem word address
//  im_wdata out  IW  imem write data
//  cpu_en   out  1   CPU enable; high only in DONE
//  busy     out  1   load in progress (HDR_LO..CSUM)
//  err      out  1   sticky error until next start or reset
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, word/byte counters 0.
//  - Frame: N_lo, N_hi (16-bit word count N, little-endian), then N words of BPW bytes,
//    each word little-endian; unused upper bits of the last byte of a word are discarded.
//  - FSM: IDLE -start-> HDR_LO -byte-> HDR_HI -byte-> DATA (N>0), DONE (N==0, no csum),
//    ERR (N>DEPTH). DATA -> (last byte of word N-1) -> CSUM if enabled, else DONE.
//    DONE/ERR -start-> HDR_LO (cpu_en and err drop the same cycle start is sampled).
//  - s_ready = 1 in HDR_LO, HDR_HI, DATA, CSUM; 0 elsewhere. Bytes with s_ready=0 are not consumed.
//  - Write: im_we pulses the cycle after the last byte of a word is accepted; im_addr = word
//    index 0..N-1, im_wdata = assembled word; addr/wdata hold between strobes.
//  - Byte counter wraps at BPW-1; word counter compared against N (16-bit), never wraps past
//    DEPTH-1 because N>DEPTH is rejected in HDR_HI. N==DEPTH is legal.
//  - s_valid gaps: any number of idle cycles between bytes; state and counters hold.
//  - start asserted while busy: ignored. Reset mid-load: immediate abort, partial imem
//    contents are left as written, cpu_en stays 0.
//  - cpu_en goes high the cycle after entering DONE's last write (i.e. never overlaps im_we).
// CONFIGURATION
//  IMEM_LOADER_CSUM_EN defined: after the last word one extra byte is expected, equal to the
//    XOR of all payload bytes (header excluded). Match -> DONE; mismatch -> ERR, cpu_en stays 0.
//    Words are still written during DATA regardless of the final checksum outcome.
//  Undefined: no CSUM state; DONE follows the last payload byte directly.
// STRUCTURE
//  - pseudocpu_pkg: loader_state_t enum (IDLE, HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR);
//    function bpw(IW) = (IW+7)/8; constant HDR_BYTES = 2.
//  - Sub-module word_assembler: shifts accepted bytes into an IW-bit register, byte
//    counter, emits word_valid pulse + word. imem_loader holds FSM, word counter, N, checksum.
// TESTING  (IW=16, DEPTH=16 unless stated)
//  - Load N=3: 03 00 34 12 78 56 BC 9A -> im_we x3: addr0=1234, addr1=5678, addr2=9ABC; cpu_en=1, err=0.
//  - N=0: 00 00 -> no im_we, DONE, cpu_en=1 two cycles after second byte (no CSUM build).
//  - N=17 (>DEPTH): 11 00 -> ERR, err=1, s_ready=0, no writes; start -> err=0, new load OK.
//  - Random s_valid gaps (50% duty) on N=16 image -> identical writes, addr 0..15, no drops.
//  - IW=12: 01 00 CD AB -> addr0=BCD (top nibble A discarded).
//  - IMEM_LOADER_CSUM_EN: 01 00 34 12 26 -> DONE; same frame with 27 -> ERR, cpu_en=0;
//    rst low mid-DATA -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and byte/word helpers.
// The optional checksum stage is compiled in with IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam int HDR_BYTES = 2;

    function automatic int bpw(input int iw);
        return (iw + 7) / 8;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, imem write port and CPU control out, for the instruction-memory loader.
// The byte link is valid/ready: a byte moves on a rising clock edge where s_valid && s_ready;
// the source holds s_data stable while s_valid is high and s_ready is low.
interface imem_loader_if #(
    parameter int IW = 16,
    parameter int AW = 8
);
    logic          start;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [IW-1:0] im_wdata;
    logic          cpu_en;
    logic          busy;
    logic          err;

    modport master (
        output start, s_data, s_valid,
        input  s_ready, im_we, im_addr, im_wdata, cpu_en, busy, err
    );

    modport slave (
        input  start, s_data, s_valid,
        output s_ready, im_we, im_addr, im_wdata, cpu_en, busy, err
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian bytes into one IW-bit word and pulses o_word_valid the cycle
// after the last byte of a word; bits above IW in the final byte are dropped.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_accept,
    input  logic [7:0]    i_byte,
    output logic          o_last,
    output logic          o_word_valid,
    output logic [IW-1:0] o_word
);
    localparam int BPW = bpw(IW);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BPW - 1);

    logic [CW-1:0]    r_cnt;
    logic [8*BPW-1:0] r_buf;
    logic [8*BPW-1:0] w_buf;
    logic             r_valid;
    logic [IW-1:0]    r_word;

    // Current byte merged into its lane, so the full word is available on the last byte.
    always_comb begin
        w_buf = r_buf;
        w_buf[8*int'(r_cnt) +: 8] = i_byte;
    end

    assign o_last       = i_accept && (r_cnt == LAST_IDX);
    assign o_word_valid = r_valid;
    assign o_word       = r_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_buf   <= '0;
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_accept) begin
                r_buf <= w_buf;
                if (r_cnt == LAST_IDX) begin
                    r_cnt   <= '0;
                    r_valid <= 1'b1;
                    r_word  <= w_buf[IW-1:0];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a [N_lo, N_hi, N words] image into imem, then enables the CPU.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR-of-payload checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IW    = 16,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  lb,
    output loader_state_t o_dbg_state
);
    localparam int AW = $clog2(DEPTH);

    loader_state_t r_state;
    logic [15:0]   r_n;
    logic [15:0]   r_word_cnt;
    logic [AW-1:0] r_addr;
    logic          r_cpu_en;
    logic          r_err;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]    r_csum;
`endif

    logic          w_busy;
    logic          w_acc;
    logic          w_clr;
    logic          w_last;
    logic          w_word_valid;
    logic [IW-1:0] w_word;
    logic [15:0]   w_n;

    assign w_busy = (r_state == HDR_LO) || (r_state == HDR_HI) ||
                    (r_state == DATA)   || (r_state == CSUM);
    assign w_acc  = lb.s_valid && w_busy;
    assign w_clr  = lb.start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_n    = {lb.s_data, r_n[7:0]};

    imem_loader_word_assembler #(.IW(IW)) u_asm (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_clr        (w_clr),
        .i_accept     (w_acc && (r_state == DATA)),
        .i_byte       (lb.s_data),
        .o_last       (w_last),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_n        <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
            r_cpu_en   <= 1'b0;
            r_err      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (lb.start) r_state <= HDR_LO;
                end
                HDR_LO: begin
                    if (w_acc) begin
                        r_n[7:0] <= lb.s_data;
                        r_state  <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (w_acc) begin
                        r_n[15:8]  <= lb.s_data;
                        r_word_cnt <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum     <= '0;
`endif
                        if (w_n == 16'd0) begin
                            r_state <= DONE;
                        end else if (w_n > 16'(DEPTH)) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_acc) begin
`ifdef IMEM_LOADER_CSUM_EN
                        r_csum <= r_csum ^ lb.s_data;
`endif
                        if (w_last) begin
                            r_addr     <= r_word_cnt[AW-1:0];
                            r_word_cnt <= r_word_cnt + 16'd1;
                            if (r_word_cnt == r_n - 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
                                r_state <= CSUM;
`else
                                r_state <= DONE;
`endif
                            end
                        end
                    end
                end
                CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
                    if (w_acc) begin
                        if (lb.s_data == r_csum) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
`else
                    r_state <= IDLE;
`endif
                end
                DONE: begin
                    // cpu_en rises one cycle after entry so it never overlaps the last write.
                    if (lb.start) begin
                        r_state  <= HDR_LO;
                        r_cpu_en <= 1'b0;
                    end else begin
                        r_cpu_en <= 1'b1;
                    end
                end
                ERR: begin
                    if (lb.start) begin
                        r_state <= HDR_LO;
                        r_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lb.s_ready   = w_busy;
    assign lb.busy      = w_busy;
    assign lb.im_we     = w_word_valid;
    assign lb.im_addr   = r_addr;
    assign lb.im_wdata  = w_word;
    assign lb.cpu_en    = r_cpu_en;
    assign lb.err       = r_err;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: IW=16 and IW=12 instances fed the same byte stream, DEPTH=16.
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       t_start;
  logic       t_valid;
  logic [7:0] t_data;

  int total = 0;
  int bad = 0;

  imem_loader_if #(.IW(16), .AW(4)) lb ();
  imem_loader_if #(.IW(12), .AW(4)) lb12 ();

  assign lb.start     = t_start;
  assign lb.s_valid   = t_valid;
  assign lb.s_data    = t_data;
  assign lb12.start   = t_start;
  assign lb12.s_valid = t_valid;
  assign lb12.s_data  = t_data;

  loader_state_t st;
  loader_state_t st12;

  imem_loader #(.IW(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .lb(lb), .o_dbg_state(st)
  );
  imem_loader #(.IW(12), .DEPTH(DEPTH)) dut12 (
    .clk(clk), .rst(rst), .lb(lb12), .o_dbg_state(st12)
  );

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  logic [15:0] exp12_q[$];
  logic [19:0] e16;
  logic [15:0] e12;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (lb.im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL write16: got addr %0h data %0h, want no write", lb.im_addr, lb.im_wdata);
      end else begin
        e16 = exp_q.pop_front();
        chk("write16", {12'h0, lb.im_addr, lb.im_wdata}, {12'h0, e16});
      end
      chk("we_cpu_en_overlap", {31'h0, lb.cpu_en}, 32'h0);
    end
    if (lb12.im_we === 1'b1) begin
      if (exp12_q.size() == 0) begin
        total++; bad++;
        $display("FAIL write12: got addr %0h data %0h, want no write", lb12.im_addr, lb12.im_wdata);
      end else begin
        e12 = exp12_q.pop_front();
        chk("write12", {16'h0, lb12.im_addr, lb12.im_wdata}, {16'h0, e12});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit gap);
    int t;
    t = 0;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      t_valid = 1'b0;
      tick();
    end
    t_valid = 1'b1;
    t_data  = d;
    while (lb.s_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) begin
      total++; bad++;
      $display("FAIL send_timeout: s_ready stayed %0b for byte %0h, want 1", lb.s_ready, d);
    end
    tick();
    t_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [15:0] w);
    exp_q.push_back({a, w});
    exp12_q.push_back({a, w[11:0]});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int            nb;
    logic [271:0]  bytes;   // byte 0 is the most significant byte of the nb used
    bit            gaps;
    bit            exp_en;
    bit            exp_err;
    logic [3:0]    last_addr;
    logic [15:0]   last_word;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int i);
    logic [7:0]  bt[$];
    logic [15:0] n;
    logic [7:0]  cs;
    int          nb;
    nb = vecs[i].nb;
    bt.delete();
    for (int k = 0; k < nb; k++) bt.push_back(vecs[i].bytes[8*(nb-1-k) +: 8]);
    n  = {bt[1], bt[0]};
    cs = 8'h00;
    if (n > 0 && n <= DEPTH) begin
      for (int j = 0; j < int'(n); j++)
        push_exp(4'(j), {bt[HDR_BYTES+2*j+1], bt[HDR_BYTES+2*j]});
      for (int k = HDR_BYTES; k < nb; k++) cs = cs ^ bt[k];
`ifdef IMEM_LOADER_CSUM_EN
      bt.push_back(cs);
`endif
    end

    pulse_start();
    chk($sformatf("v%0d_start_state", i), 32'(st), 32'(HDR_LO));
    chk($sformatf("v%0d_start_cpu_en", i), {31'h0, lb.cpu_en}, 32'h0);
    chk($sformatf("v%0d_start_err", i), {31'h0, lb.err}, 32'h0);
    chk($sformatf("v%0d_start_ready", i), {31'h0, lb.s_ready}, 32'h1);
    chk($sformatf("v%0d_start_busy", i), {31'h0, lb.busy}, 32'h1);

    foreach (bt[k]) send_byte(bt[k], vecs[i].gaps);
    if (vecs[i].exp_en)
      chk($sformatf("v%0d_cpu_en_not_early", i), {31'h0, lb.cpu_en}, 32'h0);
    tick();
    chk($sformatf("v%0d_cpu_en", i), {31'h0, lb.cpu_en}, {31'h0, vecs[i].exp_en});
    chk($sformatf("v%0d_err", i), {31'h0, lb.err}, {31'h0, vecs[i].exp_err});
    chk($sformatf("v%0d_state", i), 32'(st), vecs[i].exp_en ? 32'(DONE) : 32'(ERR));
    chk($sformatf("v%0d_ready_low", i), {31'h0, lb.s_ready}, 32'h0);
    chk($sformatf("v%0d_busy_low", i), {31'h0, lb.busy}, 32'h0);

    if (vecs[i].exp_err) begin
      t_valid = 1'b1;
      t_data  = 8'h55;
      tick();
      tick();
      t_valid = 1'b0;
      chk($sformatf("v%0d_err_holds", i), 32'(st), 32'(ERR));
    end
    tick();
    tick();
    chk($sformatf("v%0d_writes_left16", i), 32'(exp_q.size()), 32'h0);
    chk($sformatf("v%0d_writes_left12", i), 32'(exp12_q.size()), 32'h0);
    chk($sformatf("v%0d_hold_addr", i), {28'h0, lb.im_addr}, {28'h0, vecs[i].last_addr});
    chk($sformatf("v%0d_hold_wdata16", i), {16'h0, lb.im_wdata}, {16'h0, vecs[i].last_word});
    chk($sformatf("v%0d_hold_wdata12", i), {20'h0, lb12.im_wdata}, {20'h0, vecs[i].last_word[11:0]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    t_start = 1'b0;
    t_valid = 1'b0;
    t_data  = 8'h00;
    rst     = 1'b0;

    vecs[0] = '{nb: 8, bytes: 272'(64'h0300_3412_7856_BC9A), gaps: 1'b0,
                exp_en: 1'b1, exp_err: 1'b0, last_addr: 4'h2, last_word: 16'h9ABC};
    vecs[1] = '{nb: 2, bytes: 272'(16'h0000), gaps: 1'b0,
                exp_en: 1'b1, exp_err: 1'b0, last_addr: 4'h2, last_word: 16'h9ABC};
    vecs[2] = '{nb: 2, bytes: 272'(16'h1100), gaps: 1'b0,
                exp_en: 1'b0, exp_err: 1'b1, last_addr: 4'h2, last_word: 16'h9ABC};
    vecs[3] = '{nb: 34, bytes: '0, gaps: 1'b1,
                exp_en: 1'b1, exp_err: 1'b0, last_addr: 4'hF, last_word: 16'hCFFF};
    vecs[3].bytes[8*33 +: 8] = 8'h10;
    vecs[3].bytes[8*32 +: 8] = 8'h00;
    for (int j = 0; j < 16; j++) begin
      vecs[3].bytes[8*(31-2*j) +: 8] = 8'(j * 17);
      vecs[3].bytes[8*(30-2*j) +: 8] = 8'hC0 | 8'(j);
    end
    vecs[4] = '{nb: 4, bytes: 272'(32'h0100_CDAB), gaps: 1'b0,
                exp_en: 1'b1, exp_err: 1'b0, last_addr: 4'h0, last_word: 16'hABCD};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(st), 32'(IDLE));
    chk("rst_we", {31'h0, lb.im_we}, 32'h0);
    chk("rst_addr", {28'h0, lb.im_addr}, 32'h0);
    chk("rst_wdata", {16'h0, lb.im_wdata}, 32'h0);
    chk("rst_cpu_en", {31'h0, lb.cpu_en}, 32'h0);
    chk("rst_busy", {31'h0, lb.busy}, 32'h0);
    chk("rst_err", {31'h0, lb.err}, 32'h0);
    chk("rst_ready", {31'h0, lb.s_ready}, 32'h0);
    rst = 1'b1;
    tick();
    chk("idle_ready", {31'h0, lb.s_ready}, 32'h0);

    for (int i = 0; i < 5; i++) run_vec(i);

    // start while busy is ignored; the load continues unaffected
    pulse_start();
    send_byte(8'h02, 1'b0);
    chk("busy_hdr_hi", 32'(st), 32'(HDR_HI));
    pulse_start();
    chk("busy_start_ignored", 32'(st), 32'(HDR_HI));
    chk("busy_flag", {31'h0, lb.busy}, 32'h1);
    push_exp(4'h0, 16'h1111);
    push_exp(4'h1, 16'h2222);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h22, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    tick();
    chk("busy_seq_cpu_en", {31'h0, lb.cpu_en}, 32'h1);
    tick();
    tick();
    chk("busy_seq_writes_left", 32'(exp_q.size()), 32'h0);

    // asynchronous reset in the middle of DATA
    pulse_start();
    push_exp(4'h0, 16'h1234);
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h78, 1'b0);
    chk("mid_state_data", 32'(st), 32'(DATA));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 32'(st), 32'(IDLE));
    chk("mid_rst_we", {31'h0, lb.im_we}, 32'h0);
    chk("mid_rst_addr", {28'h0, lb.im_addr}, 32'h0);
    chk("mid_rst_wdata", {16'h0, lb.im_wdata}, 32'h0);
    chk("mid_rst_cpu_en", {31'h0, lb.cpu_en}, 32'h0);
    chk("mid_rst_busy", {31'h0, lb.busy}, 32'h0);
    chk("mid_rst_ready", {31'h0, lb.s_ready}, 32'h0);
    chk("mid_rst_err", {31'h0, lb.err}, 32'h0);
    #3;
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_idle", 32'(st), 32'(IDLE));
    chk("post_rst_cpu_en", {31'h0, lb.cpu_en}, 32'h0);
    chk("mid_rst_writes_left", 32'(exp_q.size()), 32'h0);

`ifdef IMEM_LOADER_CSUM_EN
    pulse_start();
    push_exp(4'h0, 16'h1234);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    chk("csum_wait_state", 32'(st), 32'(CSUM));
    send_byte(8'h26, 1'b0);
    tick();
    chk("csum_ok_state", 32'(st), 32'(DONE));
    chk("csum_ok_cpu_en", {31'h0, lb.cpu_en}, 32'h1);

    pulse_start();
    push_exp(4'h0, 16'h1234);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h27, 1'b0);
    tick();
    chk("csum_bad_state", 32'(st), 32'(ERR));
    chk("csum_bad_err", {31'h0, lb.err}, 32'h1);
    chk("csum_bad_cpu_en", {31'h0, lb.cpu_en}, 32'h0);
    tick();
    tick();
    chk("csum_writes_left", 32'(exp_q.size()), 32'h0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
